// File: rtl/alu_iterative.sv
// alu_iterative: RV32-style ALU with single-cycle fast ops and an iterative
// shift-add multiplier / restoring divider behind a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start_i, busy_o = 0
// RUN   | one multiply or divide step per cycle, busy_o = 1
// DONE  | done_o pulse, result valid; a new start_i is accepted here too
module alu_iterative #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [3:0]       ALU_Operation_i,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] ALU_Result_o,
  output logic             Zero_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] OP_MUL   = 4'hA;
  localparam logic [3:0] OP_MULHU = 4'hB;
  localparam logic [3:0] OP_DIVU  = 4'hC;
  localparam logic [3:0] OP_REMU  = 4'hD;
  localparam logic [3:0] OP_DIV   = 4'hE;
  localparam logic [3:0] OP_REM   = 4'hF;

  state_t state_q, state_d;

  // iteration registers: hi is the partial product / remainder,
  // lo is the multiplier / dividend-quotient shift register, opb the
  // multiplicand / divisor magnitude
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] hi, lo, opb;
  logic [3:0]       op_q;
  logic             neg_q, neg_r, div_zero;

  logic             accept, iter_op, signed_div, last_step, is_mul;
  logic             sign_a, sign_b;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] fast_res, iter_res;
  logic [WIDTH-1:0] hi_n, lo_n;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0] mul_add;
  logic             div_ge;

  assign accept     = start_i && ((state_q == IDLE) || (state_q == DONE));
  assign iter_op    = (ALU_Operation_i >= OP_MUL);
  assign signed_div = (ALU_Operation_i[3:1] == 3'b111);
  assign sign_a     = signed_div & A_i[WIDTH-1];
  assign sign_b     = signed_div & B_i[WIDTH-1];
  assign shamt      = B_i[SHW-1:0];
  assign last_step  = (cnt == {SHW{1'b1}});
  assign is_mul     = (op_q[3:1] == 3'b101);

  // next-state and handshake outputs
  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = iter_op ? RUN : DONE;
      end
      RUN: begin
        busy_o = 1'b1;
        if (last_step) state_d = DONE;
      end
      DONE: begin
        done_o = 1'b1;
        if (start_i) state_d = iter_op ? RUN : DONE;
        else         state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // single-cycle operations, straight from the inputs at accept
  always_comb begin
    fast_res = '0;
    case (ALU_Operation_i)
      4'h0: fast_res = A_i + B_i;
      4'h1: fast_res = A_i - B_i;
      4'h2: fast_res = A_i | B_i;
      4'h3: fast_res = A_i & B_i;
      4'h4: fast_res = A_i ^ B_i;
      4'h5: fast_res = A_i << shamt;
      4'h6: fast_res = A_i >> shamt;
      4'h7: fast_res = $unsigned($signed(A_i) >>> shamt);
      4'h8: fast_res[0] = ($signed(A_i) < $signed(B_i));
      4'h9: fast_res[0] = (A_i < B_i);
      default: fast_res = '0;
    endcase
  end

  // one multiply or divide step, plus the final sign fix-up of its outputs
  always_comb begin
    mul_add   = lo[0] ? opb : '0;
    mul_sum   = {1'b0, hi} + {1'b0, mul_add};
    div_shift = {hi, lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb};
    // the running remainder stays below the divisor, so bit WIDTH of the
    // difference is a clean borrow flag
    div_ge    = ~div_diff[WIDTH];
    if (is_mul) begin
      hi_n = mul_sum[WIDTH:1];
      lo_n = {mul_sum[0], lo[WIDTH-1:1]};
    end else begin
      hi_n = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      lo_n = {lo[WIDTH-2:0], div_ge};
    end
    iter_res = '0;
    case (op_q)
      OP_MUL:   iter_res = lo_n;
      OP_MULHU: iter_res = hi_n;
      OP_DIVU:  iter_res = lo_n;
      OP_REMU:  iter_res = hi_n;
      // divide by zero keeps the all-ones quotient regardless of signs
      OP_DIV:   iter_res = (!div_zero && neg_q) ? (-lo_n) : lo_n;
      OP_REM:   iter_res = neg_r ? (-hi_n) : hi_n;
      default:  iter_res = '0;
    endcase
  end

  // operand capture, iteration and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      hi           <= '0;
      lo           <= '0;
      opb          <= '0;
      op_q         <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      div_zero     <= 1'b0;
      ALU_Result_o <= '0;
      Zero_o       <= 1'b0;
    end else if (accept) begin
      if (iter_op) begin
        cnt      <= '0;
        hi       <= '0;
        lo       <= sign_a ? (-A_i) : A_i;
        opb      <= sign_b ? (-B_i) : B_i;
        op_q     <= ALU_Operation_i;
        neg_q    <= sign_a ^ sign_b;
        neg_r    <= sign_a;
        div_zero <= (B_i == '0);
      end else begin
        ALU_Result_o <= fast_res;
        Zero_o       <= (fast_res == '0);
      end
    end else if (state_q == RUN) begin
      hi  <= hi_n;
      lo  <= lo_n;
      cnt <= cnt + 1'b1;
      if (last_step) begin
        ALU_Result_o <= iter_res;
        Zero_o       <= (iter_res == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_iterative.sv
// tb_alu_iterative: directed and randomized checks of alu_iterative against
// an arithmetic reference model.
module tb_alu_iterative;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_i;
  logic [3:0]    op;
  logic [W-1:0]  a, b;
  logic          busy, done, zero;
  logic [W-1:0]  res;

  int n_chk  = 0;
  int n_pass = 0;

  alu_iterative #(.WIDTH(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .start_i        (start_i),
    .ALU_Operation_i(op),
    .A_i            (a),
    .B_i            (b),
    .busy_o         (busy),
    .done_o         (done),
    .ALU_Result_o   (res),
    .Zero_o         (zero)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // hard time limit so the bench always terminates
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] ref_alu(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int          sx, sy;
    logic [63:0] p;
    logic [4:0]  sh;
    bit          ovf;
    sx  = x;
    sy  = y;
    sh  = y[4:0];
    p   = {32'b0, x} * {32'b0, y};
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      4'h0: return x + y;
      4'h1: return x - y;
      4'h2: return x | y;
      4'h3: return x & y;
      4'h4: return x ^ y;
      4'h5: return x << sh;
      4'h6: return x >> sh;
      4'h7: return $unsigned(sx >>> sh);
      4'h8: return (sx < sy) ? 32'd1 : 32'd0;
      4'h9: return (x < y) ? 32'd1 : 32'd0;
      4'hA: return p[31:0];
      4'hB: return p[63:32];
      4'hC: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      4'hD: return (y == 0) ? x : x % y;
      4'hE: return (y == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : $unsigned(sx / sy);
      default: return (y == 0) ? x : ovf ? 32'd0 : $unsigned(sx % sy);
    endcase
  endfunction

  // issue one request from the current cycle and follow it to done_o;
  // operands are scrambled right after accept, and with inject an ADD
  // start is attempted in the middle of an iterative op
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit inject, input string tag);
    logic [W-1:0] exp;
    int           lat, cyc, busy_n;
    bit           got, overlap;
    exp     = ref_alu(o, x, y);
    lat     = (o >= 4'hA) ? W + 1 : 1;
    op      = o;
    a       = x;
    b       = y;
    start_i = 1'b1;
    cyc     = 0;
    busy_n  = 0;
    got     = 0;
    overlap = 0;
    while (!got && cyc < W + 8) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        start_i = 1'b0;
        op      = 4'($urandom);
        a       = $urandom;
        b       = $urandom;
      end
      if (inject && cyc == 5) begin
        start_i = 1'b1;
        op      = 4'h0;
      end
      if (inject && cyc == 6) start_i = 1'b0;
      if (busy && done) overlap = 1;
      if (busy) busy_n++;
      if (done) got = 1;
    end
    chk({tag, "_done"}, W'(got), 1);
    chk({tag, "_lat"}, W'(cyc), W'(lat));
    chk({tag, "_busy"}, W'(busy_n), W'(lat - 1));
    chk({tag, "_ovl"}, W'(overlap), 0);
    chk({tag, "_res"}, res, exp);
    chk({tag, "_zero"}, W'(zero), W'(exp == 0));
  endtask

  initial begin
    int  seen;
    logic [3:0]   ro;
    logic [W-1:0] ra, rb;

    reset   = 1'b1;
    start_i = 1'b0;
    op      = '0;
    a       = '0;
    b       = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_busy", W'(busy), 0);
    chk("rst_done", W'(done), 0);
    chk("rst_res", res, 0);
    chk("rst_zero", W'(zero), 0);

    issue(4'h0, 32'd5, 32'd7, 0, "add");
    @(posedge clk);
    #1;
    chk("done_pulse", W'(done), 0);
    issue(4'h1, 32'd3, 32'd3, 0, "sub_zero");
    issue(4'h7, 32'h8000_0000, 32'h0000_003F, 0, "sra");
    issue(4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu");
    issue(4'hA, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mul");
    issue(4'hE, -32'sd7, 32'd2, 0, "div_neg");
    issue(4'hF, -32'sd7, 32'd2, 0, "rem_neg");
    issue(4'hC, 32'd100, 32'd7, 1, "divu_inj");
    issue(4'h8, 32'hFFFF_FFFF, 32'd1, 0, "slt_b2b");
    issue(4'hD, 32'd100, 32'd7, 0, "remu");
    issue(4'hC, 32'd5, 32'd0, 0, "divu_z");
    issue(4'hF, 32'd5, 32'd0, 0, "rem_z");
    issue(4'hE, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    issue(4'hF, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");
    issue(4'h0, 32'd1, 32'd2, 0, "add_pre");

    // abort a DIV ten cycles in
    @(posedge clk);
    #1;
    op      = 4'hE;
    a       = -32'sd1000;
    b       = 32'd3;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_busy", W'(busy), 0);
    chk("abort_res", res, 0);
    chk("abort_zero", W'(zero), 0);
    seen = 0;
    repeat (W + 4) begin
      if (done || busy) seen = 1;
      @(posedge clk);
      #1;
    end
    chk("abort_nodone", W'(seen), 0);
    issue(4'h0, 32'd1, 32'd1, 0, "add_after");

    for (int i = 0; i < 150; i++) begin
      ro = 4'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(7))
        0: rb = '0;
        1: rb = W'($urandom_range(9));
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        default: ;
      endcase
      issue(ro, ra, rb, 1'($urandom), "rnd");
      if ($urandom_range(1) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
